fsm_table_ctrl: RTL and testbench
=================================

# fsm_table_ctrl

Runtime-programmable, table-driven Mealy sequence-detector engine with its own load/run controller. A host writes the full next-state/output table through a valid/ready config port, then starts detection. While running, the engine walks a serial bit stream one qualified sample at a time and pulses `done` on each match. It replaces fixed-ROM detectors: one instance can be retargeted to a new pattern without resynthesis.

## Interface

- `S_W`, 2, state register width; the table has 2^(S_W+1) entries of S_W+1 bits.
- `CNT_W`, 16, width of the match counter.
- `RST_STATE`, 0, detector state loaded at run start.

Ports:

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: table write request.
- `cfg_ready` out 1: table write accepted when high together with `cfg_valid`.
- `cfg_addr` in S_W+1: entry index `{sin, cs}`.
- `cfg_data` in S_W+1: entry value `{done, ns}`.
- `cfg_last` in 1: marks the final write of a load.
- `run_start` in 1: single-cycle request to begin detection.
- `run_stop` in 1: single-cycle request to end detection.
- `sin_valid` in 1: qualifies `sin`.
- `sin` in 1: serial data bit.
- `done` out 1: registered match pulse.
- `cs_out` out S_W: current detector state.
- `running` out 1: high while in RUN.
- `table_ok` out 1: the table is completely written.
- `cfg_err` out 1: one-cycle error pulse.
- `match_cnt` out CNT_W: saturating count of `done` pulses.

## Operation

- **Controller states:** IDLE, LOAD, RUN. Reset enters IDLE.
- **Reset values:** `table_ok`=0, `cs`=RST_STATE, `done`=0, `cfg_err`=0, `match_cnt`=0. Table RAM contents are not reset.
- **`cfg_ready`** = 1 in IDLE and LOAD, and 0 in RUN.
- **IDLE, accepted write:**
  - Go to LOAD.
  - Clear `table_ok` and the per-entry written bitmap.
  - Then write the entry and set its bitmap bit.
- **LOAD, accepted write:** write the entry and set its bitmap bit. Rewriting an entry is legal; the last value wins.
- **Accepted write with `cfg_last`:**
  - Go to IDLE.
  - If the bitmap (including this write) is full, set `table_ok`=1.
  - Otherwise pulse `cfg_err` and leave `table_ok`=0.
- **`run_start` in IDLE:**
  - With `table_ok`=1: go to RUN and set `cs`<=RST_STATE.
  - With `table_ok`=0: pulse `cfg_err` and stay in IDLE.
- **`run_start` in LOAD or RUN:** ignored.
- **`run_start` with an accepted write in IDLE:** the write wins and `run_start` is ignored.
- **RUN, `sin_valid`=1:** with entry e = table[{sin, cs}]:
  - `cs` <= e.ns
  - `done` <= e.done
  - `match_cnt` increments when e.done=1 and saturates at all-ones.
- **RUN, `sin_valid`=0:** `cs` holds and `done` <= 0.
- **`run_stop` in RUN:**
  - Go to IDLE.
  - A `sin_valid` sample in the same cycle is still processed.
  - `cs` holds its last value.
- **`run_stop` outside RUN:** ignored.
- **Counter clear:** `match_cnt` clears to 0 on each transition into RUN.
- **Writes during RUN:** cannot occur because `cfg_ready`=0, so the table is stable while detecting.

## Timing

- Config write to table: 1 cycle. An entry written in cycle N is readable from cycle N+1.
- `table_ok` rises the cycle after the `cfg_last` handshake.
- `cfg_err` asserts the cycle after the offending event and lasts exactly 1 cycle.
- `run_start` in cycle N:
  - `running`=1 from cycle N+1.
  - The first sample processed is the one at cycle N+1.
- Sample latency: `sin_valid`/`sin` at cycle N gives `done`/`cs_out` updated at cycle N+1.
- `done` is a one-cycle pulse per matching sample. Back-to-back matches give back-to-back pulses.
- `run_stop` in cycle N: `running`=0 from cycle N+1. `cfg_ready`=1 from cycle N+1.
- `rst` mid-load or mid-run: all registers return to their reset values next cycle. The partial table is invalid (`table_ok`=0), and a full reload is required.

## Configuration

- Macro `FSM_TABLE_MATCH_CNT_EN`.
- **Defined:** `match_cnt` is implemented as specified: saturating, cleared on RUN entry and on reset.
- **Undefined:** the counter is not built and `match_cnt` is tied to 0. All other behaviour is identical.

## Test plan

Test table T (S_W=2), written in address order 0..7 with `cfg_last` on address 7. T is a "101" detector with overlap:

- addr0 = 000, addr1 = 010, addr2 = 000, addr3 = 000
- addr4 = 001, addr5 = 001, addr6 = 101, addr7 = 000

Scenarios:

1. Load T, then `run_start`, then samples 1,0,1,0,1 → `table_ok`=1; `done` pulses on the cycles after the 3rd and 5th samples; `match_cnt`=2; `cs_out` ends at 1.
2. Load only addresses 0..6 with `cfg_last` on 6 → `cfg_err` pulses once; `table_ok`=0; a later `run_start` pulses `cfg_err` again and `running` stays 0.
3. In RUN, assert `run_stop` together with a sample of 1 while `cs`=2 → `done`=1 next cycle; `running`=0; `cs_out`=1; `cfg_ready`=1.
4. In IDLE with `table_ok`=1, assert `cfg_valid` and `run_start` in the same cycle → the write is accepted; the state becomes LOAD; `table_ok`=0; `running` stays 0.
5. Assert `rst` midway through stream 1,0 → next cycle `cs_out`=0, `done`=0, `table_ok`=0, `match_cnt`=0, state IDLE.
6. Force `match_cnt` near saturation (CNT_W=2 build), then send 5 matches → the count stops at 3. With `FSM_TABLE_MATCH_CNT_EN` undefined, `match_cnt` stays 0.

Source files
------------

// File: rtl/fsm_table_ctrl.sv
// fsm_table_ctrl: runtime-programmable, table-driven Mealy sequence detector.
// A host loads the {done, ns} table indexed by {sin, cs} through a valid/ready
// port, then starts detection; each qualified serial sample walks the table
// and a registered done pulse marks every match.
// Optional feature: define FSM_TABLE_MATCH_CNT_EN to build the saturating
// match counter; otherwise match_cnt is tied to 0.
module fsm_table_ctrl #(
    parameter int S_W       = 2,
    parameter int CNT_W     = 16,
    parameter int RST_STATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [S_W:0]     cfg_addr,
    input  logic [S_W:0]     cfg_data,
    input  logic             cfg_last,
    input  logic             run_start,
    input  logic             run_stop,
    input  logic             sin_valid,
    input  logic             sin,
    output logic             done,
    output logic [S_W-1:0]   cs_out,
    output logic             running,
    output logic             table_ok,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int E_W = S_W + 1;
    localparam int N   = 1 << E_W;
    localparam logic [S_W-1:0] RST_CS = S_W'(RST_STATE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [E_W-1:0] tbl [N];
    logic [N-1:0]   written;
    logic [N-1:0]   written_nxt;
    logic [N-1:0]   wr_mask;
    logic           table_ok_nxt;
    logic           cfg_err_nxt;
    logic           run_enter;
    logic           wr_en;
    logic           sample_en;
    logic [E_W-1:0] entry;
    logic [S_W-1:0] cs;

    // Writes are only accepted outside RUN, so the table never changes under the detector.
    assign cfg_ready = (state != RUN);
    assign wr_en     = cfg_valid && cfg_ready;
    assign wr_mask   = N'(1) << cfg_addr;
    assign running   = (state == RUN);
    assign sample_en = running && sin_valid;
    assign entry     = tbl[{sin, cs}];
    assign cs_out    = cs;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decisions; an accepted write takes priority over run_start.
    always_comb begin
        state_nxt    = state;
        written_nxt  = written;
        table_ok_nxt = table_ok;
        cfg_err_nxt  = 1'b0;
        run_enter    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    state_nxt    = LOAD;
                    table_ok_nxt = 1'b0;
                    written_nxt  = wr_mask;
                end else if (run_start) begin
                    if (table_ok) begin
                        state_nxt = RUN;
                        run_enter = 1'b1;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (wr_en) begin
                    written_nxt = written | wr_mask;
                end
            end
            RUN: begin
                if (run_stop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The final write closes the load and judges completeness including itself.
        if (wr_en && cfg_last) begin
            state_nxt = IDLE;
            if (&written_nxt) begin
                table_ok_nxt = 1'b1;
            end else begin
                cfg_err_nxt = 1'b1;
            end
        end
    end

    // Load bookkeeping: written bitmap, table_ok flag and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            written  <= '0;
            table_ok <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            written  <= written_nxt;
            table_ok <= table_ok_nxt;
            cfg_err  <= cfg_err_nxt;
        end
    end

    // Table RAM: contents survive reset, only the bitmap tracks validity.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    // Detector: one table step per qualified sample, state reloaded on RUN entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs   <= RST_CS;
            done <= 1'b0;
        end else if (run_enter) begin
            cs   <= RST_CS;
            done <= 1'b0;
        end else if (sample_en) begin
            cs   <= entry[S_W-1:0];
            done <= entry[S_W];
        end else begin
            done <= 1'b0;
        end
    end

`ifdef FSM_TABLE_MATCH_CNT_EN
    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] cnt;

    // Match counter, cleared on reset and on every entry into RUN.
    always_ff @(posedge clk) begin
        if (rst || run_enter) begin
            cnt <= '0;
        end else if (sample_en && entry[S_W]) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign match_cnt = cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_table_ctrl.sv
// Directed bench for fsm_table_ctrl using the "101" overlapping detector table.
module tb_fsm_table_ctrl;

    localparam int S_W   = 2;
    localparam int CNT_W = 2;
`ifdef FSM_TABLE_MATCH_CNT_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [S_W:0]     cfg_addr;
    logic [S_W:0]     cfg_data;
    logic             cfg_last;
    logic             run_start;
    logic             run_stop;
    logic             sin_valid;
    logic             sin;
    logic             done;
    logic [S_W-1:0]   cs_out;
    logic             running;
    logic             table_ok;
    logic             cfg_err;
    logic [CNT_W-1:0] match_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [S_W:0] tbl_t [8] = '{3'b000, 3'b010, 3'b000, 3'b000,
                                3'b001, 3'b001, 3'b101, 3'b000};

    fsm_table_ctrl #(.S_W(S_W), .CNT_W(CNT_W), .RST_STATE(0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .run_start (run_start),
        .run_stop  (run_stop),
        .sin_valid (sin_valid),
        .sin       (sin),
        .done      (done),
        .cs_out    (cs_out),
        .running   (running),
        .table_ok  (table_ok),
        .cfg_err   (cfg_err),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
        return MC_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [S_W:0] data, input logic last);
        cfg_valid = 1'b1;
        cfg_addr  = addr[S_W:0];
        cfg_data  = data;
        cfg_last  = last;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic load_t(input int first, input int last_addr);
        for (int a = first; a <= last_addr; a++) begin
            wr(a, tbl_t[a], a == last_addr);
        end
    endtask

    task automatic start();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
    endtask

    task automatic sample(input logic b);
        sin_valid = 1'b1;
        sin       = b;
        tick();
        sin_valid = 1'b0;
    endtask

    initial begin
        logic [4:0] s1_bits;
        logic [4:0] s1_done;
        logic [S_W-1:0] s1_cs [5];
        int k;
        s1_bits = 5'b10101;
        s1_done = 5'b00101;
        s1_cs   = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
        run_start = 1'b0; run_stop = 1'b0; sin_valid = 1'b0; sin = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // reset values
        check("rst_table_ok", table_ok, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cs", cs_out, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_running", running, 0);
        check("rst_cfg_ready", cfg_ready, 1);

        // scenario 1: load, run, stream 1,0,1,0,1
        load_t(0, 7);
        check("s1_table_ok", table_ok, 1);
        check("s1_no_err", cfg_err, 0);
        start();
        check("s1_running", running, 1);
        check("s1_ready_low", cfg_ready, 0);
        for (int i = 0; i < 5; i++) begin
            sample(s1_bits[4-i]);
            check($sformatf("s1_done_%0d", i), done, s1_done[4-i]);
            check($sformatf("s1_cs_%0d", i), cs_out, s1_cs[i]);
        end
        check("s1_cnt", match_cnt, cnt_exp(2));
        tick();
        check("s1_idle_done", done, 0);
        check("s1_idle_cs_hold", cs_out, 1);

        // scenario 3: run_stop together with a matching sample at cs=2
        sample(1'b0);
        check("s3_cs_pre", cs_out, 2);
        run_stop = 1'b1; sin_valid = 1'b1; sin = 1'b1;
        tick();
        run_stop = 1'b0; sin_valid = 1'b0;
        check("s3_done", done, 1);
        check("s3_running", running, 0);
        check("s3_cs", cs_out, 1);
        check("s3_ready", cfg_ready, 1);
        check("s3_cnt", match_cnt, cnt_exp(3));
        tick();
        check("s3_done_clear", done, 0);

        // scenario 4: write and run_start together in IDLE with table_ok=1
        cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = tbl_t[0]; cfg_last = 1'b0;
        run_start = 1'b1;
        tick();
        cfg_valid = 1'b0; run_start = 1'b0;
        check("s4_running", running, 0);
        check("s4_table_ok", table_ok, 0);
        check("s4_err", cfg_err, 0);
        start();
        check("s4_load_ignores_start_err", cfg_err, 0);
        check("s4_load_ignores_start_run", running, 0);
        load_t(1, 7);
        check("s4_reload_ok", table_ok, 1);

        // scenario 2: incomplete load
        load_t(0, 6);
        check("s2_err", cfg_err, 1);
        check("s2_table_ok", table_ok, 0);
        tick();
        check("s2_err_one_cycle", cfg_err, 0);
        start();
        check("s2_start_err", cfg_err, 1);
        check("s2_not_running", running, 0);
        tick();
        check("s2_start_err_clear", cfg_err, 0);

        // scenario 6: five matches against a 2-bit counter
        load_t(0, 7);
        check("s6_table_ok", table_ok, 1);
        start();
        check("s6_cnt_cleared", match_cnt, 0);
        k = 0;
        for (int i = 0; i < 11; i++) begin
            sample((i % 2) == 0);
            if (i >= 2 && (i % 2) == 0) begin
                k++;
            end
            check($sformatf("s6_cnt_%0d", i), match_cnt, cnt_exp(k > 3 ? 3 : k));
        end

        // scenario 5: reset midway through a stream, on a would-be match
        sample(1'b1);
        sample(1'b0);
        check("s5_cs_pre", cs_out, 2);
        rst = 1'b1; sin_valid = 1'b1; sin = 1'b1;
        tick();
        rst = 1'b0; sin_valid = 1'b0;
        check("s5_cs", cs_out, 0);
        check("s5_done", done, 0);
        check("s5_table_ok", table_ok, 0);
        check("s5_cnt", match_cnt, 0);
        check("s5_running", running, 0);
        check("s5_ready", cfg_ready, 1);
        start();
        check("s5_idle_start_err", cfg_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
